entity_table_arbiter: RTL
=========================

ENTITY_TABLE_ARBITER -- requirements
Module: entity_table_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters sharing the entity table.
REQ-002 The block SHALL have parameter N_SLOTS, default 8, the number of entity slots; a power of 2.
REQ-003 The block SHALL have parameter ENT_W, default 14, the entity word width: [13:10] ID, [9:8] orientation, [7:0] tile location.
REQ-004 clk  input  1  Clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  Reset; synchronous, active-low.
REQ-006 vblank  input  1  High while the display is in vertical blanking; the only window in which writes are permitted.
REQ-007 req  input  N_REQ  Per-requester write request, level.
REQ-008 req_slot  input  N_REQ*log2(N_SLOTS)  Packed target slot, requester i at bits [i*SW +: SW].
REQ-009 req_data  input  N_REQ*ENT_W  Packed entity word, requester i at bits [i*ENT_W +: ENT_W].
REQ-010 grant  output  N_REQ  One-hot or zero; combinational acknowledge of the write taken at the next clock edge.
REQ-011 rd_slot  input  log2(N_SLOTS)  Render-side read address.
REQ-012 rd_data  output  ENT_W  Registered table contents for rd_slot.
REQ-013 upd_count  output  8  Writes committed in the current blanking window.

Function
REQ-014 A requester SHALL hold req, req_slot and req_data stable from assertion until the cycle in which its grant bit is high, then deassert or present a new request.
REQ-015 grant SHALL be all-zero whenever vblank is 0 or req is all-zero.
REQ-016 When vblank=1 and any req is high, exactly one grant bit SHALL be set: the first requesting index found scanning ptr, ptr+1, ... mod N_REQ.
REQ-017 ptr SHALL update to (granted index + 1) mod N_REQ at the edge ending a grant cycle and hold otherwise.
REQ-018 In a grant cycle, table[req_slot of winner] SHALL be loaded with req_data of the winner at the clock edge; other slots unchanged.
REQ-019 rd_data SHALL equal table[rd_slot] sampled at the previous edge (latency 1).
REQ-020 A read and a write of the same slot in the same cycle SHALL return the old contents (read-before-write).
REQ-021 upd_count SHALL clear to 0 on the edge where vblank is sampled 1 after being 0, counting that cycle's write if any (result 1).
REQ-022 Otherwise upd_count SHALL increment by 1 per committed write and saturate at 255.
REQ-023 vblank falling while requests are pending SHALL produce no grant from that cycle on; the requests remain pending to the next window.
REQ-024 Multiple requesters targeting the same slot SHALL be serialised; the last granted write wins.

Reset
REQ-025 While rst_n=0 at an edge: all slots SHALL load {4'hF, 10'h000} (ID F = unused), ptr=0, upd_count=0, rd_data=0, and the vblank edge register=0.
REQ-026 grant SHALL be all-zero during any cycle with rst_n=0.
REQ-027 Reset asserted mid-window SHALL discard the write of that cycle.

Verification
REQ-028 After reset, read slots 0..7 -> rd_data = 14'h3C00 for each, one cycle after rd_slot applied.
REQ-029 vblank=0, req=4'b0001, slot 2, data 14'h0512 for 5 cycles -> grant=0 throughout, slot 2 unchanged; raise vblank -> grant=0001 in the same cycle, slot 2 = 14'h0512, upd_count=1.
REQ-030 vblank=1, req=4'b1111 held and each requester re-requesting after grant -> grant sequence 0001, 0010, 0100, 1000, 0001; upd_count=5.
REQ-031 Requesters 1 and 3 both write slot 5 (data 14'h1111, 14'h2222) with ptr=0 -> grant 1 then 3, slot 5 = 14'h2222.
REQ-032 260 consecutive grants in one window -> upd_count saturates at 255; next vblank rising edge with no requests -> upd_count=0.
REQ-033 rd_slot=4 during a write of 14'h0ABC to slot 4 -> rd_data shows old value next cycle, 14'h0ABC the cycle after.

Source files
------------

// File: rtl/entity_table_arbiter.sv
// ---------------------------------------------------------------------------
// entity_table_arbiter
//
// Purpose:
//   Shared entity table (N_SLOTS words of ENT_W bits) written by N_REQ
//   requesters through a round-robin arbiter, with one registered read
//   port for the renderer. Writes are only accepted while vblank is high.
//   Each entity word is [13:10] ID, [9:8] orientation, [7:0] tile location;
//   an empty slot holds ID 4'hF.
//
// Ports:
//   clk        in   1               rising-edge clock
//   rst_n      in   1               synchronous, active-low reset
//   vblank     in   1               write window enable
//   req        in   N_REQ           per-requester write request (level)
//   req_slot   in   N_REQ*SW        packed target slot, requester i at [i*SW +: SW]
//   req_data   in   N_REQ*ENT_W     packed entity word, requester i at [i*ENT_W +: ENT_W]
//   grant      out  N_REQ           one-hot/zero, combinational; write taken at next edge
//   rd_slot    in   SW              render-side read address
//   rd_data    out  ENT_W           table[rd_slot] registered (latency 1)
//   upd_count  out  8               writes committed in the current window, saturating
// ---------------------------------------------------------------------------
module entity_table_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_SLOTS = 8,
    parameter int ENT_W   = 14
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               vblank,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ*$clog2(N_SLOTS)-1:0]   req_slot,
    input  logic [N_REQ*ENT_W-1:0]             req_data,
    output logic [N_REQ-1:0]                   grant,
    input  logic [$clog2(N_SLOTS)-1:0]         rd_slot,
    output logic [ENT_W-1:0]                   rd_data,
    output logic [7:0]                         upd_count
);

    localparam int SW = $clog2(N_SLOTS);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Unused-slot marker: ID field all ones, everything else zero.
    localparam logic [ENT_W-1:0] EMPTY_ENT = {4'hF, {(ENT_W-4){1'b0}}};

    // State
    logic [ENT_W-1:0] r_table [N_SLOTS];
    logic [PW-1:0]    r_ptr;
    logic [ENT_W-1:0] r_rd_data;
    logic [7:0]       r_upd_count;
    logic             r_vblank_q;

    // Arbitration results
    logic [N_REQ-1:0] w_grant;
    logic             w_any;
    logic [PW-1:0]    w_win;
    logic [SW-1:0]    w_win_slot;
    logic [ENT_W-1:0] w_win_data;
    logic [PW-1:0]    w_ptr_next;
    logic             w_vb_rise;
    int               w_best;
    int               w_dist;

    // -----------------------------------------------------------------------
    // Round-robin pick: every requester gets its distance from r_ptr in
    // scan order (ptr, ptr+1, ... mod N_REQ); the requesting index with the
    // smallest distance wins. Indexing only by the loop variable keeps the
    // selects constant after unrolling.
    // -----------------------------------------------------------------------
    always_comb begin
        w_best = N_REQ;
        w_dist = 0;
        w_win  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = i - int'(r_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N_REQ;
            end
            if (rst_n && vblank && req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = PW'(i);
            end
        end
    end

    assign w_any = (w_best < N_REQ);

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_grant[i] = w_any && (w_win == PW'(i));
        end
    end

    assign grant = w_grant;

    // Mux the winner's slot and word out of the packed request buses.
    always_comb begin
        w_win_slot = '0;
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_slot = req_slot[i*SW +: SW];
                w_win_data = req_data[i*ENT_W +: ENT_W];
            end
        end
    end

    // Pointer moves one past the winner, wrapping for any N_REQ.
    assign w_ptr_next = (w_win == PW'(N_REQ-1)) ? '0 : w_win + PW'(1);

    // -----------------------------------------------------------------------
    // Table storage and registered read. The read samples the array with
    // its pre-edge contents, so a same-slot write this cycle shows up one
    // cycle later (read-before-write).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                r_table[s] <= EMPTY_ENT;
            end
            r_rd_data <= '0;
        end else begin
            if (w_any) begin
                r_table[w_win_slot] <= w_win_data;
            end
            r_rd_data <= r_table[rd_slot];
        end
    end

    assign rd_data = r_rd_data;

    // -----------------------------------------------------------------------
    // Arbiter pointer: only advances on an edge that commits a write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Per-window write counter. The first edge of a new window restarts the
    // count and includes that edge's own write, so a window opening with a
    // grant reads 1 afterwards.
    // -----------------------------------------------------------------------
    assign w_vb_rise = vblank && !r_vblank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vblank_q  <= 1'b0;
            r_upd_count <= 8'd0;
        end else begin
            r_vblank_q <= vblank;
            if (w_vb_rise) begin
                r_upd_count <= w_any ? 8'd1 : 8'd0;
            end else if (w_any && (r_upd_count != 8'hFF)) begin
                r_upd_count <= r_upd_count + 8'd1;
            end
        end
    end

    assign upd_count = r_upd_count;

endmodule
